riscv_com_stage: RTL and testbench
==================================

# riscv_com_stage

Commit stage (COM), stage 10 of 10 in the RV64I pipeline; consumes the registered outputs of the write-back stage. Performs the architectural register-file write, keeps the 64-bit retired-instruction counter (instret) with CSR write override, and, optionally, pushes a commit trace record per retired instruction into a small FIFO drained by a valid/ready trace port. Commit never stalls the pipeline; trace back-pressure drops records and raises a sticky overflow flag.

## Interface
- TRACE_DEPTH, 8, trace FIFO entries; power of two, ≥2

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- wb_pc  in  64  PC of instruction in WB
- wb_inst  in  32  instruction word
- wb_data  in  64  result to write
- wb_rd_addr  in  5  destination register
- wb_wr_en  in  1  destination write requested
- wb_valid  in  1  instruction in WB is valid
- csr_instret_we  in  1  CSR write to instret
- csr_instret_wdata  in  64  CSR write value
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  5  register-file write address
- rf_wr_data  out  64  register-file write data
- instret  out  64  retired-instruction count
- trace_valid  out  1  trace record available
- trace_ready  in  1  trace consumer accepts head record
- trace_pc  out  64  head record PC
- trace_inst  out  32  head record instruction
- trace_rd_addr  out  5  head record rd (0 if no write)
- trace_data  out  64  head record write data (0 if no write)
- trace_overflow  out  1  sticky: ≥1 record dropped since reset

## Operation
- Retire event: wb_valid=1. Nothing else qualifies.
- RF write: rf_wr_en ← wb_valid & wb_wr_en & (wb_rd_addr≠0); rf_wr_addr/rf_wr_data ← wb_rd_addr/wb_data registered every cycle (data path, no functional dependence on reset value beyond reset defaults below). x0 writes always suppressed.
- instret, priority per edge: csr_instret_we → load csr_instret_wdata (retire in same cycle NOT added); else retire → instret+1, wrapping 2^64−1 → 0; else hold.
- Trace FIFO: push on retire; record = {wb_pc, wb_inst, rd, data} with rd/data forced to 0 when the RF write is suppressed. Pop when trace_valid & trace_ready. Head presented combinationally from storage; trace_valid = not empty.
- Full: push with no simultaneous pop → record dropped, trace_overflow←1 (stays 1 until reset). Full with simultaneous pop → push accepted, no overflow. Empty: no bypass; pop ignored.
- Pointers: log2(TRACE_DEPTH)+1 bits, wrap naturally; full/empty from MSB comparison.

## Timing
- Reset (rst=1, asynchronous): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, instret=0, FIFO emptied (trace_valid=0), trace_overflow=0; trace_* data outputs 0 while empty. Reset mid-operation discards all queued records and in-flight write; no RF write in the cycle after rst deasserts unless wb_valid is sampled at that edge.
- Latency WB→RF write: 1 cycle (inputs sampled at edge N, rf_wr_* valid after edge N).
- instret reflects a retire sampled at edge N after edge N.
- Trace: record pushed at edge N visible on trace_valid after edge N (1 cycle); throughput 1 record/cycle.
- trace_* outputs stable while trace_valid=1 and trace_ready=0.

## Configuration
- RISCV_COM_TRACE_EN defined: trace FIFO and overflow logic built as above.
- Not defined: no FIFO storage; trace_valid=0, trace_overflow=0, all trace_* data outputs 0, trace_ready ignored. RF write and instret behaviour unchanged. Ports present in both builds.

## Test plan
- Reset then wb_valid=1, wb_wr_en=1, rd=5, data=64'hDEAD_BEEF_0000_0001 → next cycle rf_wr_en=1, addr=5, data matches; instret=1.
- wb_valid=1, wb_wr_en=1, rd=0 → rf_wr_en=0, instret increments, trace record rd=0, data=0.
- instret preloaded via CSR to 64'hFFFF_FFFF_FFFF_FFFF, then one retire → instret=0; CSR write 64'd100 same cycle as retire → instret=100.
- (TRACE_EN, depth 8) trace_ready=0, 9 consecutive retires → trace_valid=1, 8 records in order (first PC first), trace_overflow=1 after 9th; then trace_ready=1 drains exactly 8 records.
- Full FIFO, trace_ready=1 and retire same cycle → no overflow, occupancy stays 8, new record at tail.
- Assert rst while FIFO holds 3 records and instret=42 → immediately trace_valid=0, instret=0, rf_wr_en=0, trace_overflow=0.

Source files
------------

// File: rtl/riscv_com_stage.sv
// riscv_com_stage: commit stage (stage 10 of 10) of the RV64I pipeline.
// Registers the architectural register-file write, keeps the 64-bit instret
// counter (CSR write has priority over a retire) and, when RISCV_COM_TRACE_EN
// is defined, queues one commit trace record per retired instruction in a
// small FIFO drained through a valid/ready trace port.
//
// Trace handshake: a record moves from the FIFO head to the consumer on every
// rising clock edge where trace_valid_o and trace_ready_i are both high;
// trace_valid_o never depends on trace_ready_i and the head stays stable
// while it is valid and not accepted.
//
// Commit never stalls: a retire that finds the FIFO full (and no pop in the
// same cycle) drops its record and sets the sticky trace_overflow_o flag.
module riscv_com_stage #(
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] wb_pc_i,
    input  logic [31:0] wb_inst_i,
    input  logic [63:0] wb_data_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_wr_en_i,
    input  logic        wb_valid_i,
    input  logic        csr_instret_we_i,
    input  logic [63:0] csr_instret_wdata_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [63:0] rf_wr_data_o,
    output logic [63:0] instret_o,
    output logic        trace_valid_o,
    input  logic        trace_ready_i,
    output logic [63:0] trace_pc_o,
    output logic [31:0] trace_inst_o,
    output logic [4:0]  trace_rd_addr_o,
    output logic [63:0] trace_data_o,
    output logic        trace_overflow_o
);

    logic        rf_wr_en_d,   rf_wr_en_q;
    logic [4:0]  rf_wr_addr_q;
    logic [63:0] rf_wr_data_q;
    logic [63:0] instret_d,    instret_q;

    // x0 writes are suppressed; only a valid instruction can write.
    always_comb begin
        rf_wr_en_d = wb_valid_i & wb_wr_en_i & (wb_rd_addr_i != 5'd0);
        instret_d  = instret_q;
        if (csr_instret_we_i) begin
            instret_d = csr_instret_wdata_i;
        end else if (wb_valid_i) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Register-file write port and retired-instruction counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= 5'd0;
            rf_wr_data_q <= 64'd0;
            instret_q    <= 64'd0;
        end else begin
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= wb_rd_addr_i;
            rf_wr_data_q <= wb_data_i;
            instret_q    <= instret_d;
        end
    end

    assign rf_wr_en_o   = rf_wr_en_q;
    assign rf_wr_addr_o = rf_wr_addr_q;
    assign rf_wr_data_o = rf_wr_data_q;
    assign instret_o    = instret_q;

`ifdef RISCV_COM_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [63:0] pc_mem   [TRACE_DEPTH];
    logic [31:0] inst_mem [TRACE_DEPTH];
    logic [4:0]  rd_mem   [TRACE_DEPTH];
    logic [63:0] data_mem [TRACE_DEPTH];

    logic [PW:0] wr_ptr_d, wr_ptr_q;
    logic [PW:0] rd_ptr_d, rd_ptr_q;
    logic        overflow_d, overflow_q;
    logic        empty, full, push, pop;
    logic [4:0]  rec_rd;
    logic [63:0] rec_data;

    // Pointer bookkeeping: full when indices match but wrap bits differ.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        pop        = !empty && trace_ready_i;
        push       = wb_valid_i && (!full || pop);
        rec_rd     = rf_wr_en_d ? wb_rd_addr_i : 5'd0;
        rec_data   = rf_wr_en_d ? wb_data_i : 64'd0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wb_valid_i && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage is pure data path; emptiness is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q[PW-1:0]]   <= wb_pc_i;
            inst_mem[wr_ptr_q[PW-1:0]] <= wb_inst_i;
            rd_mem[wr_ptr_q[PW-1:0]]   <= rec_rd;
            data_mem[wr_ptr_q[PW-1:0]] <= rec_data;
        end
    end

    assign trace_valid_o    = !empty;
    assign trace_overflow_o = overflow_q;
    assign trace_pc_o       = empty ? 64'd0 : pc_mem[rd_ptr_q[PW-1:0]];
    assign trace_inst_o     = empty ? 32'd0 : inst_mem[rd_ptr_q[PW-1:0]];
    assign trace_rd_addr_o  = empty ? 5'd0  : rd_mem[rd_ptr_q[PW-1:0]];
    assign trace_data_o     = empty ? 64'd0 : data_mem[rd_ptr_q[PW-1:0]];
`else
    // Trace port tied off; inputs that only feed the trace are sunk here.
    localparam int UNUSED_DEPTH = TRACE_DEPTH;
    logic unused_trace;
    assign unused_trace     = ^{trace_ready_i, wb_pc_i, wb_inst_i};
    assign trace_valid_o    = 1'b0;
    assign trace_overflow_o = 1'b0;
    assign trace_pc_o       = 64'd0;
    assign trace_inst_o     = 32'd0;
    assign trace_rd_addr_o  = 5'd0;
    assign trace_data_o     = 64'd0;
`endif

endmodule

// File: tb/tb_riscv_com_stage.sv
// tb_riscv_com_stage: randomized and directed stimulus for riscv_com_stage,
// with a reference model built from the commit rules and a scoreboard
// monitor that checks every cycle's outputs and every trace record.
module tb_riscv_com_stage;

`ifdef RISCV_COM_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [63:0] instret;
        logic        tvalid;
        logic        ovf;
    } cyc_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [63:0] data;
    } rec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] wb_pc_i = '0;
    logic [31:0] wb_inst_i = '0;
    logic [63:0] wb_data_i = '0;
    logic [4:0]  wb_rd_addr_i = '0;
    logic        wb_wr_en_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic        csr_instret_we_i = 1'b0;
    logic [63:0] csr_instret_wdata_i = '0;
    logic        trace_ready_i = 1'b0;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [63:0] rf_wr_data_o;
    logic [63:0] instret_o;
    logic        trace_valid_o;
    logic [63:0] trace_pc_o;
    logic [31:0] trace_inst_o;
    logic [4:0]  trace_rd_addr_o;
    logic [63:0] trace_data_o;
    logic        trace_overflow_o;

    riscv_com_stage #(.TRACE_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_pc_i(wb_pc_i), .wb_inst_i(wb_inst_i), .wb_data_i(wb_data_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_wr_en_i(wb_wr_en_i), .wb_valid_i(wb_valid_i),
        .csr_instret_we_i(csr_instret_we_i), .csr_instret_wdata_i(csr_instret_wdata_i),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
        .instret_o(instret_o), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o),
        .trace_rd_addr_o(trace_rd_addr_o), .trace_data_o(trace_data_o),
        .trace_overflow_o(trace_overflow_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    cyc_t        exp_q[$];
    rec_t        trace_exp_q[$];

    // reference model state
    logic [63:0] m_instret = '0;
    int          m_occ = 0;
    bit          m_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; applies one cycle of inputs, updates
    // the model for the next edge and records the post-edge expectation.
    task automatic drive(input bit v, input bit we, input logic [4:0] rd,
                         input logic [63:0] data, input logic [63:0] pc,
                         input logic [31:0] inst, input bit csr_we,
                         input logic [63:0] csr_wd, input bit rdy);
        cyc_t e;
        rec_t r;
        bit   wr, pop;
        wb_valid_i = v; wb_wr_en_i = we; wb_rd_addr_i = rd; wb_data_i = data;
        wb_pc_i = pc; wb_inst_i = inst; csr_instret_we_i = csr_we;
        csr_instret_wdata_i = csr_wd; trace_ready_i = rdy;

        wr = v && we && (rd != 5'd0);
        if (csr_we)  m_instret = csr_wd;
        else if (v)  m_instret = m_instret + 64'd1;
        if (TRACE_EN) begin
            pop = (m_occ > 0) && rdy;
            if (v) begin
                if (m_occ < DEPTH || pop) begin
                    r.pc = pc; r.inst = inst;
                    r.rd = wr ? rd : 5'd0;
                    r.data = wr ? data : 64'd0;
                    trace_exp_q.push_back(r);
                    m_occ++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) m_occ--;
        end
        e.en = wr; e.addr = rd; e.data = data; e.instret = m_instret;
        e.tvalid = (m_occ > 0); e.ovf = m_ovf;
        @(posedge clk_i);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 0, 64'd0, rdy);
    endtask

    task automatic retire(input logic [4:0] rd, input logic [63:0] data, input bit rdy);
        drive(1, 1, rd, data, {$urandom, $urandom} & ~64'h3, $urandom, 0, 64'd0, rdy);
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear at once.
    task automatic do_reset();
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_rf_wr_en", rf_wr_en_o, 64'd0);
        check("rst_rf_wr_addr", rf_wr_addr_o, 64'd0);
        check("rst_rf_wr_data", rf_wr_data_o, 64'd0);
        check("rst_instret", instret_o, 64'd0);
        check("rst_trace_valid", trace_valid_o, 64'd0);
        check("rst_trace_overflow", trace_overflow_o, 64'd0);
        check("rst_trace_pc", trace_pc_o, 64'd0);
        check("rst_trace_data", trace_data_o, 64'd0);
        wb_valid_i = 0; wb_wr_en_i = 0; csr_instret_we_i = 0; trace_ready_i = 0;
        exp_q.delete();
        trace_exp_q.delete();
        m_instret = '0; m_occ = 0; m_ovf = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        cyc_t e;
        rec_t r;
        if (!rst_i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_wr_en", rf_wr_en_o, e.en);
            check("rf_wr_addr", rf_wr_addr_o, e.addr);
            check("rf_wr_data", rf_wr_data_o, e.data);
            check("instret", instret_o, e.instret);
            check("trace_valid", trace_valid_o, e.tvalid);
            check("trace_overflow", trace_overflow_o, e.ovf);
            if (trace_valid_o) begin
                if (trace_exp_q.size() == 0) begin
                    check("trace_unexpected_record", 64'd1, 64'd0);
                end else begin
                    r = trace_exp_q[0];
                    check("trace_pc", trace_pc_o, r.pc);
                    check("trace_inst", trace_inst_o, r.inst);
                    check("trace_rd", trace_rd_addr_o, r.rd);
                    check("trace_data", trace_data_o, r.data);
                    if (trace_ready_i) void'(trace_exp_q.pop_front());
                end
            end else begin
                check("trace_pc_idle", trace_pc_o, 64'd0);
                check("trace_data_idle", trace_data_o, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // power-on reset
        #1;
        check("por_instret", instret_o, 64'd0);
        check("por_rf_wr_en", rf_wr_en_o, 64'd0);
        check("por_trace_valid", trace_valid_o, 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // basic write, then x0 write (suppressed, trace rd/data forced to 0)
        drive(1, 1, 5'd5, 64'hDEAD_BEEF_0000_0001, 64'h1000, 32'h0050_0293, 0, 64'd0, 0);
        drive(1, 1, 5'd0, 64'h1234_5678_9ABC_DEF0, 64'h1004, 32'h0000_0013, 0, 64'd0, 0);
        drive(1, 0, 5'd7, 64'h5555, 64'h1008, 32'h0000_0063, 0, 64'd0, 0);

        // instret wrap and CSR write beating a same-cycle retire
        drive(0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        retire(5'd3, 64'hA, 0);
        drive(1, 1, 5'd4, 64'hB, 64'h2000, 32'h0000_0033, 1, 64'd100, 0);
        idle(12, 1);

        // fill exactly, then pop+push on a full FIFO, then overflow, then drain
        for (int i = 0; i < DEPTH; i++) retire(5'($urandom_range(0, 31)), {$urandom, $urandom}, 0);
        retire(5'd9, 64'h99, 1);
        retire(5'd10, 64'h100, 0);
        idle(12, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom},
                  $urandom_range(0, 2) == 0);
        end
        idle(12, 1);

        // reset with three queued records and instret=42
        drive(0, 0, 5'd0, 64'd0, 64'd0, 32'd0, 1, 64'd39, 0);
        for (int i = 0; i < 3; i++) retire(5'(i + 1), 64'(i), 0);
        do_reset();
        retire(5'd6, 64'h66, 1);
        idle(4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
